machine_timer_clint: RTL and testbench
======================================

Name: machine_timer_clint

Overview:
- Memory-mapped machine timer and software-interrupt source (CLINT-style) for the RV32IM core.
- Sits directly upstream of the CSR unit: its registered irq outputs drive interrupts_i[7] (MTIP) and interrupts_i[3] (MSIP).
- Software reaches it over the core's simple 32-bit peripheral bus (valid/ready request, one-cycle registered response).
- Provides 64-bit mtime, 64-bit mtimecmp and a 1-bit msip register.

Parameters:
- PRESCALE, 1, clk cycles per mtime increment (legal range 1..65535; 1 = increment every cycle).
- MTIMECMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp; no timer irq out of reset.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  bus request valid
- req_ready  output  1  bus request accepted this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  16  byte offset within block
- req_wdata  input  32  write data
- rsp_valid  output  1  response valid, one cycle after acceptance
- rsp_rdata  output  32  read data (0 for writes and errors)
- rsp_err  output  1  unmapped or misaligned access
- timer_irq  output  1  MTIP, to CSR unit interrupts_i[7]
- soft_irq  output  1  MSIP, to CSR unit interrupts_i[3]
- mtime_o  output  64  current mtime, for the time/timeh shadow CSRs

Behaviour:
- Reset is asynchronous, active-low, clock clk. Reset values:
  - mtime = 0, mtimecmp = MTIMECMP_RESET, msip = 0, prescale counter = 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, timer_irq = 0, soft_irq = 0.
- Address map (word offsets; req_addr[1:0] != 0 -> error):
  - 0x0000 msip: bit0 RW, bits 31:1 read 0.
  - 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
  - Any other offset -> error.
- Handshake:
  - req_ready = 1 whenever rst_n is deasserted and no response is pending the same cycle, so at most one outstanding request.
  - Back-to-back accesses are therefore one every 2 cycles.
  - An accepted request in cycle N gives rsp_valid = 1 for exactly cycle N+1.
  - Read data is the register value sampled at cycle N, before any same-cycle tick.
  - Errors: rsp_err = 1, rsp_rdata = 0, no register state changes.
- Prescaler:
  - Counter runs 0..PRESCALE-1. tick is asserted when the counter equals PRESCALE-1, and the counter then wraps to 0.
  - With PRESCALE = 1, tick is asserted every cycle.
  - On tick, mtime <= mtime + 1 as a 64-bit add, wrapping from all-ones to 0.
- Write/tick collision:
  - Writing either half of mtime in a tick cycle: the written half takes the written value and the other half keeps its pre-tick value. The increment is dropped for that cycle, with no carry.
  - The prescale counter is not affected by bus writes.
- Timer irq:
  - timer_irq is registered: timer_irq <= (mtime >= mtimecmp), an unsigned 64-bit compare using current register values.
  - Latency is 1 cycle after the register update.
  - Split 32-bit writes to mtimecmp may produce a transient irq. This is accepted; software writes hi = all-ones, then lo, then hi.
- Soft irq: soft_irq <= msip, registered, 1-cycle latency after the msip write lands. It stays asserted until software clears msip.
- The block never clears mtimecmp or msip by itself; the level irq persists until software reprograms them.
- mtime_o is a direct copy of the mtime register, not delayed.
- Reset mid-transaction drops any pending response. No rsp_valid appears after reset release without a new request.

Test Plan:
- Reset release, PRESCALE = 1, idle 10 cycles -> mtime_o = 10 (±1 for release edge), timer_irq = 0, soft_irq = 0, reading 0x4004 gives rsp_rdata = 32'hFFFFFFFF one cycle after acceptance.
- Write 0x4004 = 0, then 0x4000 = 20, with mtime < 20 -> timer_irq rises in the cycle after mtime reaches 20. Writing 0x4000 = 0xFFFFFFFF and 0x4004 = 0xFFFFFFFF then drops timer_irq one cycle after the last write.
- Write 0x0000 = 1 -> soft_irq = 1 two cycles after acceptance. Write 0x0000 = 0 -> soft_irq = 0. Reading 0x0000 after writing 0xFFFFFFFF returns 1.
- PRESCALE = 4: mtime increments once per 4 cycles. Write mtime lo = 0xFFFFFFFF, hi = 0 -> the next tick gives mtime = 0x1_0000_0000 (carry into hi). Preset mtime = all-ones -> the next tick wraps to 0.
- Write mtime lo = 0x100 in a tick cycle -> mtime lo = 0x100 after that cycle with no increment that cycle, and hi is unchanged.
- Read 0x0002 (misaligned) and read 0x1234 (unmapped) -> rsp_err = 1, rsp_rdata = 0, no state change. Assert rst_n low while a response is pending -> all outputs return to reset values and no stray rsp_valid appears.

Source files
------------

// File: rtl/machine_timer_clint.sv
// Purpose: CLINT-style machine timer (64-bit mtime/mtimecmp) and software-interrupt register for the RV32IM core.
// Latency: a bus response comes one cycle after acceptance; the irq outputs are registered one cycle after the compare inputs.
// Backpressure: at most one request is outstanding; req_ready drops while a response is pending, so accesses run one every two cycles.
module machine_timer_clint #(
    parameter int unsigned PRESCALE       = 1,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        timer_irq,
    output logic        soft_irq,
    output logic [63:0] mtime_o
);

    localparam logic [15:0] ADDR_MSIP    = 16'h0000;
    localparam logic [15:0] ADDR_CMP_LO  = 16'h4000;
    localparam logic [15:0] ADDR_CMP_HI  = 16'h4004;
    localparam logic [15:0] ADDR_TIME_LO = 16'hBFF8;
    localparam logic [15:0] ADDR_TIME_HI = 16'hBFFC;
    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic [15:0] pre_cnt;
    logic        tick;
    logic        accept;
    logic        wr;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_time_lo;
    logic        sel_time_hi;
    logic        addr_err;
    logic [31:0] rd_val;

    // Ready is tied to reset so nothing is accepted while the block is held in reset.
    assign req_ready = rst_n & ~rsp_valid;
    assign accept    = req_valid & req_ready;
    assign wr        = accept & req_we;
    assign tick      = (pre_cnt == PRESCALE_MAX);
    assign mtime_o   = mtime;

    // Address decode; misaligned offsets never match an entry and so fall into the error case.
    always_comb begin
        sel_msip    = 1'b0;
        sel_cmp_lo  = 1'b0;
        sel_cmp_hi  = 1'b0;
        sel_time_lo = 1'b0;
        sel_time_hi = 1'b0;
        addr_err    = 1'b0;
        rd_val      = 32'd0;
        case (req_addr)
            ADDR_MSIP: begin
                sel_msip = 1'b1;
                rd_val   = {31'd0, msip};
            end
            ADDR_CMP_LO: begin
                sel_cmp_lo = 1'b1;
                rd_val     = mtimecmp[31:0];
            end
            ADDR_CMP_HI: begin
                sel_cmp_hi = 1'b1;
                rd_val     = mtimecmp[63:32];
            end
            ADDR_TIME_LO: begin
                sel_time_lo = 1'b1;
                rd_val      = mtime[31:0];
            end
            ADDR_TIME_HI: begin
                sel_time_hi = 1'b1;
                rd_val      = mtime[63:32];
            end
            default: addr_err = 1'b1;
        endcase
    end

    // Free-running prescaler; bus writes never disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= 16'd0;
        end else if (tick) begin
            pre_cnt <= 16'd0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // mtime: a write to either half wins over the tick and suppresses that cycle's increment entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= 64'd0;
        end else if (wr && sel_time_lo) begin
            mtime[31:0] <= req_wdata;
        end else if (wr && sel_time_hi) begin
            mtime[63:32] <= req_wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Software-owned compare and msip registers; only bus writes change them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp <= MTIMECMP_RESET;
            msip     <= 1'b0;
        end else begin
            if (wr && sel_cmp_lo) mtimecmp[31:0]  <= req_wdata;
            if (wr && sel_cmp_hi) mtimecmp[63:32] <= req_wdata;
            if (wr && sel_msip)   msip            <= req_wdata[0];
        end
    end

    // One-cycle registered response; read data reflects register values before this cycle's updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept & addr_err;
            rsp_rdata <= (accept && !req_we && !addr_err) ? rd_val : 32'd0;
        end
    end

    // Level interrupts, registered from the current register values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_irq <= 1'b0;
            soft_irq  <= 1'b0;
        end else begin
            timer_irq <= (mtime >= mtimecmp);
            soft_irq  <= msip;
        end
    end

endmodule

// File: tb/tb_machine_timer_clint.sv
// Bench for machine_timer_clint: two instances (PRESCALE 1 and 4) share one bus.
// A cycle-level model of the register map is checked against both every cycle,
// and directed accesses pin the model with hand-computed values.
module tb_machine_timer_clint;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [15:0] req_addr  = 16'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        rdy [2];
    logic        rv  [2];
    logic        re  [2];
    logic        ti  [2];
    logic        si  [2];
    logic [31:0] rd  [2];
    logic [63:0] mt  [2];

    int n_assert = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    machine_timer_clint #(.PRESCALE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]),
        .timer_irq(ti[0]), .soft_irq(si[0]), .mtime_o(mt[0])
    );

    machine_timer_clint #(.PRESCALE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]),
        .timer_irq(ti[1]), .soft_irq(si[1]), .mtime_o(mt[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          presc [2] = '{1, 4};
    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];
    logic        m_ti   [2];
    logic        m_si   [2];
    logic [31:0] m_rd   [2];
    int          m_cnt  [2];
    logic        m_rv;
    logic        m_re;

    function automatic bit mapped(input logic [15:0] a);
        return (a == 16'h0000) || (a == 16'h4000) || (a == 16'h4004) ||
               (a == 16'hBFF8) || (a == 16'hBFFC);
    endfunction

    function automatic logic [31:0] mreg(input int k, input logic [15:0] a);
        case (a)
            16'h0000: return {31'd0, m_msip[k]};
            16'h4000: return m_cmp[k][31:0];
            16'h4004: return m_cmp[k][63:32];
            16'hBFF8: return m_time[k][31:0];
            16'hBFFC: return m_time[k][63:32];
            default:  return 32'd0;
        endcase
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_time[k] = 64'd0;
            m_cmp[k]  = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip[k] = 1'b0;
            m_ti[k]   = 1'b0;
            m_si[k]   = 1'b0;
            m_rd[k]   = 32'd0;
            m_cnt[k]  = 0;
        end
        m_rv = 1'b0;
        m_re = 1'b0;
    endtask

    initial begin
        bit          acc;
        bit          err;
        bit          twr;
        logic [63:0] nt;
        logic [31:0] rdv;
        logic        nti;
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mreset();
            end else begin
                acc = req_valid && !m_rv;
                err = !mapped(req_addr);
                for (int k = 0; k < 2; k++) begin
                    rdv = mreg(k, req_addr);
                    nti = (m_time[k] >= m_cmp[k]);
                    m_si[k] = m_msip[k];
                    nt  = m_time[k];
                    twr = 1'b0;
                    if (acc && req_we && !err) begin
                        case (req_addr)
                            16'h0000: m_msip[k] = req_wdata[0];
                            16'h4000: m_cmp[k][31:0]  = req_wdata;
                            16'h4004: m_cmp[k][63:32] = req_wdata;
                            16'hBFF8: begin nt[31:0]  = req_wdata; twr = 1'b1; end
                            16'hBFFC: begin nt[63:32] = req_wdata; twr = 1'b1; end
                            default: ;
                        endcase
                    end
                    if (!twr && m_cnt[k] == presc[k] - 1) nt = nt + 64'd1;
                    m_time[k] = nt;
                    m_cnt[k]  = (m_cnt[k] + 1) % presc[k];
                    m_ti[k]   = nti;
                    m_rd[k]   = (acc && !req_we && !err) ? rdv : 32'd0;
                end
                m_rv = acc;
                m_re = acc && err;
            end
        end
    end

    // Per-cycle comparison of both instances against the model (or reset values).
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    check($sformatf("u%0d reset outputs", k),
                          {rdy[k], rv[k], re[k], ti[k], si[k], rd[k]}, 37'd0);
                    check($sformatf("u%0d reset mtime", k), mt[k], 64'd0);
                end else begin
                    check($sformatf("u%0d req_ready", k), rdy[k], !m_rv);
                    check($sformatf("u%0d rsp_valid", k), rv[k], m_rv);
                    check($sformatf("u%0d rsp_err", k), re[k], m_re);
                    check($sformatf("u%0d rsp_rdata", k), rd[k], m_rd[k]);
                    check($sformatf("u%0d mtime_o", k), mt[k], m_time[k]);
                    check($sformatf("u%0d timer_irq", k), ti[k], m_ti[k]);
                    check($sformatf("u%0d soft_irq", k), si[k], m_si[k]);
                end
            end
        end
    end

    // One bus access; entered and left at 1 time unit after a rising edge.
    task automatic bus(input logic we, input logic [15:0] a, input logic [31:0] d,
                       output logic [31:0] r1, output logic [31:0] r4, output logic er);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!rdy[0] && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("bus ready", rdy[0], 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("bus rsp_valid", rv[0], 1'b1);
        r1 = rd[0];
        r4 = rd[1];
        er = re[0];
        @(posedge clk);
        #1;
    endtask

    task automatic wait_time_ne(input int k, input logic [63:0] v);
        int n = 0;
        while (mt[k] == v && n < 16) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mtime change within budget", (mt[k] != v), 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r1, r4, hi;
        logic        er;
        int          n;

        repeat (3) @(posedge clk);
        #1 started = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        repeat (10) @(posedge clk);
        #1;
        check("idle mtime ~10", (mt[0] >= 64'd9 && mt[0] <= 64'd11), 1'b1);
        check("idle timer_irq", ti[0], 1'b0);
        check("idle soft_irq", si[0], 1'b0);
        bus(1'b0, 16'h4004, 32'd0, r1, r4, er);
        check("reset mtimecmp hi", r1, 32'hFFFF_FFFF);

        // Timer interrupt at mtime == 20
        bus(1'b1, 16'h4004, 32'd0, r1, r4, er);
        bus(1'b1, 16'h4000, 32'd20, r1, r4, er);
        n = 0;
        while (mt[0] != 64'd20 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mtime reached 20", mt[0], 64'd20);
        check("irq not yet at 20", ti[0], 1'b0);
        @(posedge clk);
        #1 check("irq one cycle later", ti[0], 1'b1);
        bus(1'b1, 16'h4000, 32'hFFFF_FFFF, r1, r4, er);
        bus(1'b1, 16'h4004, 32'hFFFF_FFFF, r1, r4, er);
        check("irq dropped", ti[0], 1'b0);

        // Software interrupt
        bus(1'b1, 16'h0000, 32'd1, r1, r4, er);
        check("soft_irq set", si[0], 1'b1);
        bus(1'b1, 16'h0000, 32'd0, r1, r4, er);
        check("soft_irq clear", si[0], 1'b0);
        bus(1'b1, 16'h0000, 32'hFFFF_FFFF, r1, r4, er);
        bus(1'b0, 16'h0000, 32'd0, r1, r4, er);
        check("msip readback", r1, 32'd1);
        bus(1'b1, 16'h0000, 32'd0, r1, r4, er);

        // Carry from lo into hi
        bus(1'b1, 16'hBFFC, 32'd0, r1, r4, er);
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, r1, r4, er);
        check("u1 carry", mt[0], 64'h1_0000_0000);
        wait_time_ne(1, 64'h0_FFFF_FFFF);
        check("u4 carry", mt[1], 64'h1_0000_0000);

        // Full wrap to zero
        bus(1'b1, 16'hBFFC, 32'hFFFF_FFFF, r1, r4, er);
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, r1, r4, er);
        check("u1 wrap", mt[0], 64'd0);
        wait_time_ne(1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("u4 wrap", mt[1], 64'd0);

        // Write mtime lo in a u4 tick cycle
        wait_time_ne(1, mt[1]);
        repeat (3) @(posedge clk);
        #1;
        hi        = mt[1][63:32];
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'hBFF8;
        req_wdata = 32'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("u4 collision", mt[1], {hi, 32'h100});
        check("u1 collision lo", mt[0][31:0], 32'h100);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1 check("u4 no tick yet", mt[1], {hi, 32'h100});

        // Error accesses
        bus(1'b0, 16'h0002, 32'd0, r1, r4, er);
        check("misaligned err", er, 1'b1);
        check("misaligned rdata", r1, 32'd0);
        bus(1'b0, 16'h1234, 32'd0, r1, r4, er);
        check("unmapped err", er, 1'b1);
        check("unmapped rdata", r1, 32'd0);
        bus(1'b1, 16'h4002, 32'd0, r1, r4, er);
        check("misaligned write err", er, 1'b1);
        bus(1'b0, 16'h4000, 32'd0, r1, r4, er);
        check("cmp lo unchanged", r1, 32'hFFFF_FFFF);
        check("cmp lo read ok", er, 1'b0);

        // Reset with a response pending
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'hBFF8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("pending rsp", rv[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("rsp dropped", rv[0], 1'b0);
        check("ready low in reset", rdy[0], 1'b0);
        check("mtime cleared", mt[1], 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 check("no stray rsp", rv[0] | rv[1], 1'b0);
        end
        check("mtime after reset", mt[0], 64'd6);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
